config_frame_loader: RTL
========================

Name: config_frame_loader

Overview:
- Write-side counterpart of the per-tile configuration-bit consumers.
- Accepts a 32-bit configuration word stream from the host/UART bridge, assembles one frame of NumRows x 32 bits, then fires a one-hot FrameStrobe that latches the frame into the tile configuration storage.
- Sits at fabric top between the bitstream source and the FrameData/FrameStrobe distribution network.

Parameters:
NumRows, 2, number of 32-bit words per frame; FrameData width = NumRows*32
NumFrames, 20, number of frame strobes (frame index range 0..NumFrames-1)
SyncWord, 32'hFAB0_FAB1, pattern that opens a configuration session

Ports:
CLK  input  1  clock; all state on rising edge
reset  input  1  synchronous, active-high reset
WriteData  input  32  configuration word
WriteStrobe  input  1  WriteData valid this cycle
Ready  output  1  loader can accept a word this cycle
FrameData  output  NumRows*32  assembled frame data
FrameStrobe  output  NumFrames  one-hot frame latch pulse
Active  output  1  a session is open (state != IDLE)
Done  output  1  one-cycle pulse on a valid END command
Error  output  1  sticky bad-command flag

Behaviour:
- Interface: one clock (CLK); reset is synchronous and active-high.
- Accept rule: a word is consumed when WriteStrobe && Ready in the same cycle. Words presented while Ready=0 are ignored, not queued.
- Reset values: FrameData=0, FrameStrobe=0, Ready=1, Active=0, Done=0, Error=0, state=IDLE, word counter=0.
- States:
  - IDLE:
    - Ready=1.
    - Accepted word == SyncWord -> CMD; also clears Error.
    - Any other word is discarded; state stays IDLE.
  - CMD:
    - Ready=1.
    - Accepted word with bit31=1 (END) -> Done=1 for exactly the next cycle, then IDLE.
    - bit31=0: index = WriteData[7:0].
      - index < NumFrames -> store index, word counter=0, go to DATA.
      - index >= NumFrames -> Error=1 (sticky), go to IDLE.
    - Bits [30:8] are ignored.
  - DATA:
    - Ready=1.
    - Accepted word k (0-based) is written to FrameData[32*k +: 32]; counter increments.
    - On the acceptance of word NumRows-1 -> STROBE.
  - STROBE:
    - Lasts exactly 1 cycle; Ready=0.
    - FrameStrobe[index]=1; all other FrameStrobe bits are 0.
    - FrameData is stable and holds the complete frame.
    - Next cycle -> CMD, FrameStrobe=0.
- Timing:
  - Latency from acceptance of the last data word to FrameStrobe high: 1 cycle.
  - FrameStrobe is a registered output, never combinational from inputs.
- FrameData holds its last value after STROBE until overwritten word-by-word by the next frame. It is not cleared between frames.
- Active = 1 in CMD, DATA and STROBE.
- Word counter width is $clog2(NumRows) with a minimum of 1. It never wraps in DATA, because the transition to STROBE occurs at NumRows-1.
- Gaps in WriteStrobe during DATA are allowed; state and counter hold.
- SyncWord received in CMD or DATA has no special meaning: it is treated as data or as a command word.
- Reset asserted mid-frame (any state): next cycle all outputs return to their reset values and the partial frame is discarded. An in-progress FrameStrobe is dropped immediately.
- Reset takes priority over a simultaneous WriteStrobe; that word is lost.
- Error is cleared only by reset or by an accepted SyncWord in IDLE.

Test Plan:
- Reset, then SyncWord, CMD 32'h0000_0003, data 32'h1111_1111, 32'h2222_2222 -> one cycle after the second data word: FrameStrobe=20'h00008, FrameData=64'h2222_2222_1111_1111; next cycle FrameStrobe=0, Ready=1.
- Words 32'h0, 32'hDEAD_BEEF in IDLE, then SyncWord -> Active stays 0 until SyncWord is accepted, then Active=1; no FrameStrobe at any point.
- SyncWord, then CMD 32'h0000_0014 (index 20) -> Error=1, Active=0, no strobe. A following SyncWord -> Error=0.
- SyncWord, CMD frame 19, two data words with 3-cycle WriteStrobe gaps, then CMD 32'h8000_0000 -> FrameStrobe[19] pulses once; Done pulses one cycle after END is accepted; Active=0 afterward.
- WriteStrobe held high during the STROBE cycle with data 32'hAAAA_AAAA -> word not accepted (Ready=0); the following CMD-state word is interpreted as a command.
- reset asserted after the first data word of frame 5 -> next cycle FrameData=0, FrameStrobe=0, state IDLE; frame 5 is never strobed.

Source files
------------

// File: rtl/config_frame_loader.sv
// config_frame_loader
// Assembles NumRows x 32-bit configuration frames from a host word stream and
// fires a one-hot FrameStrobe so the addressed frame latches FrameData.
//
// state  | meaning
// IDLE   | no session; only SyncWord is recognised, everything else discarded
// CMD    | session open; next word is a frame index or END (bit31)
// DATA   | collecting frame words into FrameData, lowest word first
// STROBE | one-cycle FrameStrobe pulse for the stored index; input stalled
module config_frame_loader #(
    parameter int          NumRows   = 2,
    parameter int          NumFrames = 20,
    parameter logic [31:0] SyncWord  = 32'hFAB0_FAB1
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic [31:0]           WriteData,
    input  logic                  WriteStrobe,
    output logic                  Ready,
    output logic [NumRows*32-1:0] FrameData,
    output logic [NumFrames-1:0]  FrameStrobe,
    output logic                  Active,
    output logic                  Done,
    output logic                  Error
);

    localparam int CntW = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam int IdxW = (NumFrames > 1) ? $clog2(NumFrames) : 1;
    localparam logic [CntW-1:0]      LastWord  = CntW'(NumRows - 1);
    localparam logic [NumFrames-1:0] StrobeOne = NumFrames'(1);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA,
        STROBE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CntW-1:0] word_cnt;
    logic [IdxW-1:0] frame_idx;

    logic accept;
    logic is_sync;
    logic cmd_is_end;
    logic cmd_idx_ok;
    logic load_idx;
    logic write_word;
    logic fire_strobe;
    logic set_done;
    logic set_error;
    logic clr_error;

    // The only stall point is the strobe cycle, so Ready is a pure state decode.
    assign Ready      = (state != STROBE);
    assign Active     = (state != IDLE);
    assign accept     = WriteStrobe && Ready;
    assign is_sync    = (WriteData == SyncWord);
    assign cmd_is_end = WriteData[31];
    // Bits [30:8] of a command word carry no meaning and are not looked at.
    assign cmd_idx_ok = ({24'd0, WriteData[7:0]} < 32'(NumFrames));

    // State register.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the single-cycle datapath enables for this word.
    always_comb begin
        state_next  = state;
        load_idx    = 1'b0;
        write_word  = 1'b0;
        fire_strobe = 1'b0;
        set_done    = 1'b0;
        set_error   = 1'b0;
        clr_error   = 1'b0;
        case (state)
            IDLE: begin
                if (accept && is_sync) begin
                    clr_error  = 1'b1;
                    state_next = CMD;
                end
            end
            CMD: begin
                if (accept) begin
                    if (cmd_is_end) begin
                        set_done   = 1'b1;
                        state_next = IDLE;
                    end else if (cmd_idx_ok) begin
                        load_idx   = 1'b1;
                        state_next = DATA;
                    end else begin
                        set_error  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    write_word = 1'b1;
                    if (word_cnt == LastWord) begin
                        fire_strobe = 1'b1;
                        state_next  = STROBE;
                    end
                end
            end
            STROBE: begin
                state_next = CMD;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Frame index, word counter and word-by-word frame assembly.
    // FrameData is deliberately not cleared between frames, only on reset.
    always_ff @(posedge CLK) begin
        if (reset) begin
            frame_idx <= '0;
            word_cnt  <= '0;
            FrameData <= '0;
        end else begin
            if (load_idx) begin
                frame_idx <= WriteData[IdxW-1:0];
                word_cnt  <= '0;
            end
            if (write_word) begin
                FrameData[32*int'(word_cnt) +: 32] <= WriteData;
                if (word_cnt != LastWord) begin
                    word_cnt <= word_cnt + CntW'(1);
                end
            end
        end
    end

    // Registered one-hot strobe, high only during the STROBE cycle.
    always_ff @(posedge CLK) begin
        if (reset) begin
            FrameStrobe <= '0;
        end else if (fire_strobe) begin
            FrameStrobe <= StrobeOne << frame_idx;
        end else begin
            FrameStrobe <= '0;
        end
    end

    // Done pulses for one cycle after END; Error is sticky until reset or a new session.
    always_ff @(posedge CLK) begin
        if (reset) begin
            Done  <= 1'b0;
            Error <= 1'b0;
        end else begin
            Done <= set_done;
            if (set_error) begin
                Error <= 1'b1;
            end else if (clr_error) begin
                Error <= 1'b0;
            end
        end
    end

endmodule
